// File: rtl/uart_pkg.sv
// uart_pkg: shared receive-path state encoding, frame constants and
// helpers for bit-timing derivation and majority voting.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 10;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   function automatic int mid_of(input int cpb);
      return cpb / 2;
   endfunction

   function automatic logic maj3(input logic a,
                                 input logic b,
                                 input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rx_sync_edge.sv
// rx_sync_edge: two-flop synchroniser plus edge-history flop for the RX line.
// Ports: CLOCK_50, reset in; rx_in async in; line_sync, fall_pulse out.
module rx_sync_edge (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic rx_in,
   output logic line_sync,
   output logic fall_pulse
);

   logic r_s1;
   logic r_s2;
   logic r_prev;

   // History resets to 0 so a line held low out of reset is not a start.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_s1   <= rx_in;
         r_s2   <= r_s1;
         r_prev <= r_s2;
      end
   end

   assign line_sync  = r_s2;
   assign fall_pulse = r_prev & ~r_s2;

endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: start-bit qualify, mid-bit 3-sample majority vote, one
// shift pulse per frame bit, then frame_valid / frame_err pulse.
// Ports: CLOCK_50, reset, rx_in in; shift_en, bit_out, frame_valid,
// frame_err, busy out.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 115200
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic rx_in,
   output logic shift_en,
   output logic bit_out,
   output logic frame_valid,
   output logic frame_err,
   output logic busy
);

   localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
   localparam int MID = mid_of(CPB);
   localparam int CW  = $clog2(CPB);

   logic          w_line;
   logic          w_fall;
   logic          w_active;
   logic          w_samp_pt;
   logic          w_decide;
   logic          w_vote;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bitcnt;
   logic [1:0]    r_samp;
   logic          r_vote;
   logic          r_shift_en;
   logic          r_bit_out;
   logic          r_frame_valid;
   logic          r_frame_err;

   rx_sync_edge u_sync (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .rx_in      (rx_in),
      .line_sync  (w_line),
      .fall_pulse (w_fall)
   );

   assign w_active  = (r_state == START) ||
                      (r_state == DATA)  ||
                      (r_state == STOP);
   assign w_samp_pt = (r_cnt == CW'(MID + 1));
   assign w_decide  = (r_cnt == CW'(MID + 2));
   // Third sample is taken live so the pulse lands on count MID+2.
   assign w_vote    = maj3(r_samp[0], r_samp[1], w_line);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_bitcnt      <= '0;
         r_samp        <= '0;
         r_vote        <= 1'b0;
         r_shift_en    <= 1'b0;
         r_bit_out     <= 1'b0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_shift_en    <= 1'b0;
         r_bit_out     <= 1'b0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;

         if (w_active) begin
            r_cnt <= (r_cnt == CW'(CPB - 1)) ? '0 : r_cnt + CW'(1);
            if (r_cnt == CW'(MID - 1))
               r_samp[0] <= w_line;
            if (r_cnt == CW'(MID))
               r_samp[1] <= w_line;
            if (w_samp_pt) begin
               r_vote <= w_vote;
               // A high vote in START is a false start: no shift.
               if ((r_state != START) || !w_vote) begin
                  r_shift_en <= 1'b1;
                  r_bit_out  <= w_vote;
               end
            end
         end

         case (r_state)
            IDLE: begin
               if (w_fall) begin
                  r_cnt   <= '0;
                  r_state <= START;
               end
            end
            START: begin
               if (w_decide) begin
                  if (r_vote) begin
                     r_state <= IDLE;
                  end else begin
                     r_bitcnt <= '0;
                     r_state  <= DATA;
                  end
               end
            end
            DATA: begin
               if (w_decide) begin
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'(DATA_BITS - 1))
                     r_state <= STOP;
               end
            end
            STOP: begin
               if (w_decide)
                  r_state <= DONE;
            end
            DONE: begin
               // Frame flag lands in the first IDLE cycle.
               r_frame_valid <= r_vote;
               r_frame_err   <= ~r_vote;
               r_state       <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign shift_en    = r_shift_en;
   assign bit_out     = r_bit_out;
   assign frame_valid = r_frame_valid;
   assign frame_err   = r_frame_err;
   assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed frames at 10 clocks per bit against a
// downstream ten-bit shift register model.
module tb_uart_rx_sampler;
   import uart_pkg::*;

   logic CLOCK_50 = 1'b0;
   logic reset;
   logic rx_in;
   logic shift_en;
   logic bit_out;
   logic frame_valid;
   logic frame_err;
   logic busy;

   uart_rx_sampler #(
      .CLK_HZ (1000),
      .BAUD   (100)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .rx_in       (rx_in),
      .shift_en    (shift_en),
      .bit_out     (bit_out),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int cyc = 0;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   logic       sh_bit[$];
   int         sh_cyc[$];
   logic [7:0] fv_byte[$];
   logic [9:0] sr = '0;
   int n_sh = 0;
   int n_fv = 0;
   int n_fe = 0;
   int fv_cyc_last = 0;
   int fe_cyc_last = 0;
   int viol = 0;

   always @(negedge CLOCK_50) begin
      if (!reset) begin
         if (shift_en) begin
            sh_bit.push_back(bit_out);
            sh_cyc.push_back(cyc);
            sr   <= {bit_out, sr[9:1]};
            n_sh <= n_sh + 1;
         end
         if (frame_valid) begin
            fv_byte.push_back(sr[8:1]);
            fv_cyc_last <= cyc;
            n_fv        <= n_fv + 1;
         end
         if (frame_err) begin
            fe_cyc_last <= cyc;
            n_fe        <= n_fe + 1;
         end
         if ((frame_valid && frame_err) || (shift_en && !busy))
            viol <= viol + 1;
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic drv(input logic v, input int n);
      rx_in = v;
      tick(n);
   endtask

   task automatic send(input logic [7:0] d,
                       input logic stop,
                       input int spike,
                       output int t0);
      logic [9:0] f;
      f  = {stop, d, 1'b0};
      t0 = cyc;
      for (int i = 0; i < 100; i++) begin
         rx_in = (i == spike) ? 1'b1 : f[i / 10];
         tick(1);
      end
   endtask

   function automatic logic [4:0] outs();
      return {shift_en, bit_out, frame_valid, frame_err, busy};
   endfunction

   function automatic logic [9:0] seq_at(input int b);
      logic [9:0] v;
      v = '0;
      for (int i = 0; i < 10; i++)
         if (b + i < sh_bit.size()) v[i] = sh_bit[b + i];
      return v;
   endfunction

   function automatic int cyc_at(input int i);
      return (i < sh_cyc.size()) ? sh_cyc[i] : -1;
   endfunction

   function automatic logic [7:0] byte_at(input int i);
      return (i < fv_byte.size()) ? fv_byte[i] : 8'hxx;
   endfunction

   function automatic int bad_gaps(input int b, input int n);
      int bad;
      bad = 0;
      for (int i = 1; i < n; i++) begin
         if (b + i >= sh_cyc.size())
            bad++;
         else if (sh_cyc[b + i] - sh_cyc[b + i - 1] != 10)
            bad++;
      end
      return bad;
   endfunction

   int b, f, e, bf, t0, t1, c0;

   initial begin
      reset = 1'b1;
      rx_in = 1'b1;
      tick(3);
      @(negedge CLOCK_50);
      chk("rst_outs", 32'(outs()), 0);
      tick(1);
      reset = 1'b0;
      @(negedge CLOCK_50);
      chk("post_rst_outs", 32'(outs()), 0);
      tick(5);

      // 1: plain 0xA5 frame
      b = n_sh; f = n_fv; e = n_fe; bf = fv_byte.size();
      send(8'hA5, 1'b1, -1, t0);
      drv(1'b1, 20);
      chk("s1_nshift", n_sh - b, FRAME_BITS);
      chk("s1_seq", 32'(seq_at(b)), 32'h34A);
      chk("s1_first_lat", cyc_at(b) - t0, 10);
      chk("s1_gaps", bad_gaps(b, 10), 0);
      chk("s1_nfv", n_fv - f, 1);
      chk("s1_fv_lat", fv_cyc_last - cyc_at(b + 9), 2);
      chk("s1_byte", 32'(byte_at(bf)), 32'hA5);
      chk("s1_nfe", n_fe - e, 0);

      // 2: 3-cycle low glitch is a false start
      b = n_sh; f = n_fv; e = n_fe;
      c0 = cyc;
      rx_in = 1'b0;
      tick(3);
      rx_in = 1'b1;
      @(negedge CLOCK_50);
      chk("s2_busy_c3", 32'(busy), 1);
      tick(7);
      @(negedge CLOCK_50);
      chk("s2_busy_c10", 32'(busy), 1);
      tick(1);
      @(negedge CLOCK_50);
      chk("s2_busy_c11", 32'(busy), 0);
      chk("s2_cyc", cyc - c0, 11);
      drv(1'b1, 20);
      chk("s2_nshift", n_sh - b, 0);
      chk("s2_nflags", (n_fv - f) + (n_fe - e), 0);

      // 3: 0x3C with low stop bit, then break
      b = n_sh; f = n_fv; e = n_fe;
      send(8'h3C, 1'b0, -1, t0);
      drv(1'b0, 30);
      chk("s3_nshift", n_sh - b, FRAME_BITS);
      chk("s3_seq", 32'(seq_at(b)), 32'h078);
      chk("s3_nfe", n_fe - e, 1);
      chk("s3_nfv", n_fv - f, 0);
      chk("s3_fe_lat", fe_cyc_last - cyc_at(b + 9), 2);
      @(negedge CLOCK_50);
      chk("s3_break_idle", 32'(busy), 0);
      drv(1'b1, 30);
      chk("s3_after_rise", n_sh - b, FRAME_BITS);
      chk("s3_fe_once", n_fe - e, 1);

      // 4: back-to-back 0x00, 0xFF with one stop bit
      b = n_sh; f = n_fv; e = n_fe; bf = fv_byte.size();
      send(8'h00, 1'b1, -1, t0);
      send(8'hFF, 1'b1, -1, t1);
      drv(1'b1, 20);
      chk("s4_nshift", n_sh - b, 2 * FRAME_BITS);
      chk("s4_gaps", bad_gaps(b, 20), 0);
      chk("s4_nfv", n_fv - f, 2);
      chk("s4_byte0", 32'(byte_at(bf)), 32'h00);
      chk("s4_byte1", 32'(byte_at(bf + 1)), 32'hFF);
      chk("s4_nfe", n_fe - e, 0);

      // 5: reset during data bit 4, line low at release
      b = n_sh;
      rx_in = 1'b0;
      tick(55);
      reset = 1'b1;
      tick(2);
      chk("s5_pre_rst", n_sh - b, 5);
      reset = 1'b0;
      @(negedge CLOCK_50);
      chk("s5_rel_outs", 32'(outs()), 0);
      tick(1);
      @(negedge CLOCK_50);
      chk("s5_rel_outs2", 32'(outs()), 0);
      b = n_sh; f = n_fv; e = n_fe; bf = fv_byte.size();
      drv(1'b0, 30);
      chk("s5_low_quiet", n_sh - b, 0);
      chk("s5_low_idle", 32'(busy), 0);
      drv(1'b1, 20);
      send(8'h81, 1'b1, -1, t0);
      drv(1'b1, 20);
      chk("s5_nshift", n_sh - b, FRAME_BITS);
      chk("s5_byte", 32'(byte_at(bf)), 32'h81);

      // 6: spike lands on the count-MID sample of data bit 2
      b = n_sh; bf = fv_byte.size();
      send(8'h00, 1'b1, 36, t0);
      drv(1'b1, 20);
      chk("s6_nshift", n_sh - b, FRAME_BITS);
      chk("s6_spike_bit", 32'(seq_at(b) >> 3) & 1, 0);
      chk("s6_seq", 32'(seq_at(b)), 32'h200);
      chk("s6_byte", 32'(byte_at(bf)), 32'h00);

      chk("invariants", viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
Front end of the serial receive path. It sits directly upstream of the ten-bit receive shift register. It synchronises the raw RX line, detects and qualifies the start bit, and majority-samples each bit at mid-period. For every accepted bit it issues a one-cycle shift enable plus the sampled bit value, so one frame (start, 8 data LSB-first, stop) gives exactly 10 shifts. It then flags frame completion or a framing error for the downstream consumer.

Parameters:
CLK_HZ, 50000000, clock frequency in Hz.
BAUD, 115200, line bit rate.
CLKS_PER_BIT, CLK_HZ/BAUD (integer, 434), clocks per bit; must be >= 8.

Ports:
CLOCK_50  in  1  system clock.
reset  in  1  synchronous, active-high reset.
rx_in  in  1  asynchronous serial line; idles high.
shift_en  out  1  one-cycle pulse; downstream shift register shifts bit_out in.
bit_out  out  1  majority-voted bit value; valid only when shift_en=1.
frame_valid  out  1  one-cycle pulse; downstream parallel byte is valid this cycle.
frame_err  out  1  one-cycle pulse; stop bit sampled 0.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset and CLOCK_50 as already decided): state=IDLE, bit counter=0, baud counter=0. Synchroniser flops and edge-history flop=0. All outputs 0. Reset mid-frame aborts with no further pulses.
- Input path: 2-flop synchroniser, then edge-history flop. A falling edge is prev=1 and cur=0. Because the history resets to 0, a line held low at reset release never triggers a start; it must go high first.
- MID = CLKS_PER_BIT/2. The baud counter runs 0..CLKS_PER_BIT-1 and wraps.
- Each bit is sampled at counts MID-1, MID and MID+1, and majority-of-3 forms the bit value. Decision cycle is count MID+2; shift_en/bit_out pulse in that cycle only.
- Successive shift_en pulses within a frame are exactly CLKS_PER_BIT cycles apart.
- IDLE: on a falling edge, clear the baud counter and go to START.
- START: at decision, a vote of 1 is a false start. No shift_en; return to IDLE. A vote of 0 pulses shift_en with bit_out=0, sets the bit counter to 0 and goes to DATA.
- DATA: at each decision, pulse shift_en with the vote and increment the bit counter. After the 8th data bit (counter=7), go to STOP.
- STOP: at decision, pulse shift_en with the vote (10th shift), then go to DONE.
- DONE: waits 1 cycle, then goes to IDLE. frame_valid (vote=1) or frame_err (vote=0) pulses exactly 2 cycles after the 10th shift_en, covering the downstream shift plus output-register latency. This pulse coincides with the first IDLE cycle.
- A new start edge is accepted from that first IDLE cycle onward. This gives back-to-back frames with 1 stop bit about MID cycles of margin.
- After frame_err with the line still low (break), no new frame starts until the line returns high and falls again.
- frame_valid and frame_err are never both 1. shift_en is never high in IDLE or DONE.

Decomposition:
- Shared package uart_pkg:
  - state encoding IDLE/START/DATA/STOP/DONE (3 bits);
  - CLKS_PER_BIT and MID derivation;
  - DATA_BITS=8 and FRAME_BITS=10 constants.
- One natural sub-module, rx_sync_edge: 2-flop synchroniser plus falling-edge detector, with outputs line_sync and fall_pulse.

Test Plan:
Run the bench with CLK_HZ=1000 and BAUD=100, so CLKS_PER_BIT=10 and MID=5. Each scenario drives the downstream ten-bit shift register model.
1. Send frame 0xA5 -> 10 shift_en pulses 10 cycles apart with bit_out sequence 0,1,0,1,0,0,1,0,1,1. frame_valid 2 cycles after the last pulse; downstream byte=0xA5; frame_err never high.
2. rx_in low for 3 cycles then high (glitch) -> no shift_en. busy high until count 7 of START, then 0.
3. Send 0x3C with stop bit 0, hold the line low 30 cycles, then high -> 10 shifts (last bit_out=0) and one frame_err, no frame_valid. No activity until the line rises and falls again.
4. Send 0x00 then 0xFF back-to-back with a single stop bit -> 20 shift_en pulses and two frame_valid pulses. Bytes 0x00 then 0xFF.
5. Assert reset during data bit 4 with rx_in low at release -> the cycle after reset has all outputs 0. No start until rx_in goes high then low.
6. Send 0x00 with a one-cycle high spike at count MID of data bit 2 -> that bit_out is 0 (majority); byte=0x00.
